adder_share_ctrl: RTL and testbench
===================================

Name: adder_share_ctrl

Overview:
- Round-robin controller that shares one `ripplecarryadder` instance between NUM_REQ requesters.
- Each requester presents an operand pair with a request line. The controller grants one requester, latches its operands, and waits a fixed number of cycles for the ripple carry chain to settle. It then returns a registered sum and carry and acknowledges the requester.
- Sits between arithmetic clients (counters, accumulators, display test logic) and the single adder datapath, so that a slow ripple adder can be safely time-multiplexed at full clock rate.

Parameters:
- BITS, 16, operand and sum width.
- NUM_REQ, 4, number of requesters (2..8).
- SETTLE_CYCLES, 2, cycles the adder output is allowed to settle before capture (>= 1).

Ports:
- in_clk  input  1  system clock, rising edge.
- in_rst  input  1  synchronous reset, active high.
- in_req  input  NUM_REQ  per-requester request; held high until matching ack.
- in_a  input  NUM_REQ*BITS  operand a, requester i in bits [i*BITS +: BITS].
- in_b  input  NUM_REQ*BITS  operand b, same packing.
- out_ack  output  NUM_REQ  one-cycle completion pulse, one-hot.
- out_sum  output  BITS  registered sum of the served request.
- out_carry  output  1  registered carry out of the served request.
- out_valid  output  1  high for one cycle together with out_ack.
- out_busy  output  1  high while a request is latched (states SETTLE and DONE).
- out_grant_idx  output  clog2(NUM_REQ)  index of the requester currently or last served.

Behaviour:
- Clocking and reset
  - Single clock domain.
  - Reset is synchronous and active-high: sampled on the rising edge of in_clk while in_rst=1.
  - Reset values:
    - state=IDLE
    - out_ack=0, out_valid=0, out_busy=0
    - out_sum=0, out_carry=0
    - out_grant_idx=0
    - internal last-grant pointer = NUM_REQ-1, so requester 0 has first priority.
- Datapath
  - One `ripplecarryadder` instantiated with BITS+1 width.
  - Its inputs are the zero-extended latched operands.
  - sum = result[BITS-1:0], carry = result[BITS].
  - Adder inputs come only from internal operand registers, never directly from in_a/in_b.
- State machine
  - IDLE
    - If in_req != 0, select the first set bit searching upward from last_grant+1, wrapping modulo NUM_REQ.
    - Latch that requester's in_a/in_b, set out_grant_idx, load settle counter = SETTLE_CYCLES-1, go to SETTLE.
    - Otherwise stay in IDLE.
  - SETTLE
    - out_busy=1.
    - If counter=0: register out_sum/out_carry from the adder, go to DONE.
    - Else decrement the counter.
  - DONE
    - out_valid=1; out_ack[out_grant_idx]=1; out_busy=1.
    - last_grant <= out_grant_idx; go to IDLE.
- Latency
  - Request accepted at IDLE edge k; out_valid/out_ack are high during cycle k+SETTLE_CYCLES+1.
  - Throughput: one operation per SETTLE_CYCLES+2 cycles.
- Handshake rules
  - Requesters must hold in_req and their operands stable until ack.
  - Changes to in_a/in_b after the grant edge do not affect the result.
  - A requester dropping in_req mid-operation does not abort it: the result and ack are still produced.
  - The requester must keep in_req high after ack only if it wants another operation. A still-high in_req in the IDLE cycle after DONE is treated as a new request, subject to round-robin.
- Boundary conditions
  - Arbitration: simultaneous requests are served in round-robin order, with no starvation.
  - Single requester: it is served back-to-back.
  - Overflow: the sum wraps modulo 2^BITS, with the carry reported in out_carry.
    - Example: 16'hFFFF + 16'h0001 gives sum 16'h0000, carry 1.
  - Output stability: out_sum/out_carry/out_grant_idx hold their last values until the next capture or grant.
  - Reset mid-operation (any state): return to IDLE next edge; no ack is produced; all outputs take reset values.
  - in_req bits of index >= NUM_REQ do not exist; the selection logic covers exactly NUM_REQ bits.

Test Plan:
- Reset, single request:
  - Stimulus: reset 2 cycles, then req0 with a=16'h1234, b=16'h2345, SETTLE_CYCLES=2.
  - Required: out_valid/out_ack=4'b0001 exactly 3 cycles after the grant edge, with out_sum=16'h3579, out_carry=0.
- Overflow:
  - Stimulus: req2 with a=16'hFFFF, b=16'h0001.
  - Required: out_sum=16'h0000, out_carry=1, out_grant_idx=2.
- Round robin:
  - Stimulus: in_req=4'b1111 held continuously, distinct operand pairs per requester.
  - Required: acks in order 0,1,2,3,0; each sum correct; an ack every 4 cycles.
- Operand stability:
  - Stimulus: change in_a of the granted requester during SETTLE.
  - Required: result reflects the operands latched at grant.
- Reset mid-operation:
  - Stimulus: assert in_rst while in SETTLE.
  - Required: no ack; outputs at reset values; a fresh req1 afterwards is served normally.
- Request withdrawal:
  - Stimulus: drop req3 one cycle after its grant.
  - Required: ack on bit 3 still pulses with the correct sum; the next grant goes to the next pending requester.

Source files
------------

// File: rtl/adder_share_ctrl.sv
// Round-robin arbiter time-sharing one ripple carry adder
// between NUM_REQ requesters, with fixed settle time.

module ripplecarryadder #(
  parameter int W = 17
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] s
);

  logic [W-1:0] c;

  assign c[0] = 1'b0;

  // bitwise full-adder chain, carry ripples upward
  for (genvar i = 0; i < W; i++) begin : g_fa
    assign s[i] = a[i] ^ b[i] ^ c[i];
    if (i < W - 1) begin : g_c
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

endmodule

module adder_share_ctrl #(
  parameter int BITS          = 16,
  parameter int NUM_REQ       = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                    in_clk,
  input  logic                    in_rst,
  input  logic [NUM_REQ-1:0]      in_req,
  input  logic [NUM_REQ*BITS-1:0] in_a,
  input  logic [NUM_REQ*BITS-1:0] in_b,
  output logic [NUM_REQ-1:0]      out_ack,
  output logic [BITS-1:0]         out_sum,
  output logic                    out_carry,
  output logic                    out_valid,
  output logic                    out_busy,
  output logic [$clog2(NUM_REQ)-1:0] out_grant_idx
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    DONE
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   cnt_q;
  logic [BITS-1:0] opa_q;
  logic [BITS-1:0] opb_q;
  logic [BITS-1:0] sum_q;
  logic            carry_q;
  logic [IW-1:0]   gidx_q;
  logic [IW-1:0]   last_q;
  logic [IW-1:0]   sel;
  logic            found;
  logic [BITS:0]   res;

  ripplecarryadder #(
    .W(BITS + 1)
  ) u_rca (
    .a({1'b0, opa_q}),
    .b({1'b0, opb_q}),
    .s(res)
  );

  // first pending request strictly after the last one served
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int o = 1; o <= NUM_REQ; o++) begin
      if (!found && in_req[(int'(last_q) + o) % NUM_REQ]) begin
        found = 1'b1;
        sel   = IW'((int'(last_q) + o) % NUM_REQ);
      end
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (found) state_d = SETTLE;
      SETTLE:  if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge in_clk) begin
    if (in_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // operand latch, settle count, result capture, rr pointer
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      gidx_q  <= '0;
      last_q  <= IW'(NUM_REQ - 1);
    end else begin
      unique case (state_q)
        IDLE: begin
          if (found) begin
            opa_q  <= in_a[int'(sel)*BITS +: BITS];
            opb_q  <= in_b[int'(sel)*BITS +: BITS];
            gidx_q <= sel;
            cnt_q  <= CW'(SETTLE_CYCLES - 1);
          end
        end
        SETTLE: begin
          if (cnt_q == '0) begin
            sum_q   <= res[BITS-1:0];
            carry_q <= res[BITS];
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE:    last_q <= gidx_q;
        default: ;
      endcase
    end
  end

  assign out_valid     = (state_q == DONE);
  assign out_busy      = (state_q != IDLE);
  assign out_ack       = out_valid ? (NUM_REQ'(1) << gidx_q) : '0;
  assign out_sum       = sum_q;
  assign out_carry     = carry_q;
  assign out_grant_idx = gidx_q;

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Bench for adder_share_ctrl: cycle model plus
// directed vectors with literal expectations.

module tb_adder_share_ctrl;

  localparam int BITS = 16;
  localparam int N    = 4;
  localparam int S    = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*BITS-1:0] a;
  logic [N*BITS-1:0] b;
  logic [N-1:0]    ack;
  logic [BITS-1:0] sum;
  logic            carry;
  logic            valid;
  logic            busy;
  logic [1:0]      gidx;

  int total = 0;
  int bad   = 0;

  adder_share_ctrl #(
    .BITS(BITS),
    .NUM_REQ(N),
    .SETTLE_CYCLES(S)
  ) dut (
    .in_clk(clk),
    .in_rst(rst),
    .in_req(req),
    .in_a(a),
    .in_b(b),
    .out_ack(ack),
    .out_sum(sum),
    .out_carry(carry),
    .out_valid(valid),
    .out_busy(busy),
    .out_grant_idx(gidx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // model: an operation started at grant completes S+1 cycles
  // later; the result is a+b of the operands seen at grant
  bit        m_on  = 0;
  bit        m_op  = 0;
  int        m_t   = 0;
  int        m_idx = 0;
  int        m_last = N - 1;
  logic [16:0] m_full = '0;
  logic [16:0] m_out  = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_on = 1; m_op = 0; m_t = 0; m_idx = 0;
      m_last = N - 1; m_full = '0; m_out = '0;
    end else if (m_on) begin
      if (!m_op) begin
        for (int o = 1; o <= N; o++) begin
          int j;
          j = (m_last + o) % N;
          if (!m_op && req[j]) begin
            m_op = 1; m_t = 0; m_idx = j;
            m_full = {1'b0, a[j*BITS +: BITS]}
                   + {1'b0, b[j*BITS +: BITS]};
          end
        end
      end else begin
        m_t++;
        if (m_t == S) m_out = m_full;
        if (m_t == S + 1) begin
          m_op = 0; m_last = m_idx;
        end
      end
    end
  end

  // compare every cycle once the model is anchored by reset
  always @(negedge clk) begin
    if (m_on) begin
      bit v;
      v = m_op && (m_t == S);
      chk("valid", 32'(valid), 32'(v));
      chk("ack", 32'(ack), v ? 32'(1 << m_idx) : 32'd0);
      chk("busy", 32'(busy), 32'(m_op));
      chk("sum", 32'(sum), 32'(m_out[15:0]));
      chk("carry", 32'(carry), 32'(m_out[16]));
      chk("gidx", 32'(gidx), 32'(m_idx));
    end
  end

  task automatic set_op(input int i, input logic [15:0] av,
                        input logic [15:0] bv);
    a[i*BITS +: BITS] = av;
    b[i*BITS +: BITS] = bv;
  endtask

  // wait for out_valid, n = posedges elapsed
  task automatic wait_ack(output int idx, output int n);
    idx = -1;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      n++;
      if (valid) begin
        for (int j = 0; j < N; j++)
          if (ack[j]) idx = j;
        return;
      end
    end
    chk("ack_timeout", 32'(n), 32'd0);
  endtask

  int idx;
  int n;
  int order[5];
  int gaps[5];

  initial begin
    rst = 1; req = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    chk("rst_sum", 32'(sum), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_gidx", 32'(gidx), 32'h0);

    set_op(0, 16'h1234, 16'h2345);
    req = 4'b0001;
    wait_ack(idx, n);
    req = '0;
    chk("t1_lat", 32'(n), 32'd3);
    chk("t1_ack", 32'(ack), 32'h1);
    chk("t1_sum", 32'(sum), 32'h3579);
    chk("t1_carry", 32'(carry), 32'h0);

    @(negedge clk);
    set_op(2, 16'hFFFF, 16'h0001);
    req = 4'b0100;
    wait_ack(idx, n);
    req = '0;
    chk("ov_sum", 32'(sum), 32'h0);
    chk("ov_carry", 32'(carry), 32'h1);
    chk("ov_gidx", 32'(gidx), 32'h2);

    @(negedge clk);
    set_op(0, 16'h1000, 16'h0011);
    req = 4'b0001;
    @(negedge clk);
    set_op(0, 16'hFFFF, 16'h0011);
    wait_ack(idx, n);
    req = '0;
    chk("stab_sum", 32'(sum), 32'h1011);

    @(negedge clk);
    set_op(3, 16'h0F0F, 16'h1111);
    set_op(0, 16'h0002, 16'h0003);
    req = 4'b1001;
    @(negedge clk);
    req = 4'b0001;
    wait_ack(idx, n);
    chk("wd_idx", 32'(idx), 32'd3);
    chk("wd_sum", 32'(sum), 32'h2020);
    wait_ack(idx, n);
    req = '0;
    chk("wd_next", 32'(idx), 32'd0);
    chk("wd_sum2", 32'(sum), 32'h0005);

    @(negedge clk);
    set_op(2, 16'h4444, 16'h4444);
    req = 4'b0100;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    req = '0;
    chk("mr_busy", 32'(busy), 32'h0);
    chk("mr_valid", 32'(valid), 32'h0);
    chk("mr_sum", 32'(sum), 32'h0);
    repeat (4) @(negedge clk);
    set_op(1, 16'hABCD, 16'h1111);
    req = 4'b0010;
    wait_ack(idx, n);
    req = '0;
    chk("mr_idx", 32'(idx), 32'd1);
    chk("mr_sum2", 32'(sum), 32'hBCDE);

    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < N; i++)
      set_op(i, 16'(16'h1111 * (i + 1)), 16'(16'h0101 * (i + 3)));
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_ack(idx, n);
      order[i] = idx;
      gaps[i] = n;
    end
    req = '0;
    chk("rr_0", 32'(order[0]), 32'd0);
    chk("rr_1", 32'(order[1]), 32'd1);
    chk("rr_2", 32'(order[2]), 32'd2);
    chk("rr_3", 32'(order[3]), 32'd3);
    chk("rr_4", 32'(order[4]), 32'd0);
    for (int i = 1; i < 5; i++)
      chk("rr_gap", 32'(gaps[i]), 32'd4);
    chk("rr_sum0", 32'(sum), 32'h1414);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
